// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - sample request/ready handshake between a data source and perceptron_trainer
interface perceptron_trainer_if #(
    parameter int NUM_IN = 2,
    parameter int XW     = 7
);
    logic [NUM_IN*XW-1:0] x_in;
    logic [1:0]           t_in;
    logic                 data_ready;
    logic                 request;

    modport master (output x_in, output t_in, output data_ready, input request);
    modport slave  (input x_in, input t_in, input data_ready, output request);
endinterface

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - online perceptron trainer (Rosenblatt rule), one sample per 3 cycles
// Define PERCEPTRON_SAT_EN for saturating weight/bias updates; default build wraps two's complement.
module perceptron_trainer #(
    parameter int NUM_IN    = 2,
    parameter int XW        = 7,
    parameter int WW        = 14,
    parameter int LR_SHIFT  = 0,
    parameter int MAX_EPOCH = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          n_samples,
    perceptron_trainer_if.slave  smp,
    output logic                 done,
    output logic                 converged,
    output logic [NUM_IN*WW-1:0] w,
    output logic [WW-1:0]        b,
    output logic [15:0]          epoch_count
);
    // NW holds NUM_IN (<=8) products plus bias without overflow; UW holds one update before clamp/wrap
    localparam int NW = XW + WW + 4;
    localparam int UW = XW + WW + LR_SHIFT + 2;
    localparam logic [15:0]          EPOCH_LIMIT = 16'(MAX_EPOCH);
    localparam logic signed [UW-1:0] B_STEP      = UW'(1) <<< LR_SHIFT;
`ifdef PERCEPTRON_SAT_EN
    localparam logic signed [UW-1:0] W_MAX = UW'((64'sd1 <<< (WW - 1)) - 64'sd1);
    localparam logic signed [UW-1:0] W_MIN = -W_MAX - UW'(1);
`endif

    typedef enum logic [2:0] {IDLE, REQ, COMPUTE, UPDATE, EPOCH_END, DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_IN*XW-1:0] x_r;
    logic [1:0]           t_r;
    logic signed [NW-1:0] net_r, net_c;
    logic [31:0]          cnt, n_r;
    logic                 err;
    logic [15:0]          ep_next;
    logic                 ep_limit, last_sample, mis;

    function automatic logic [WW-1:0] upd(input logic [WW-1:0] cur, input logic signed [UW-1:0] step);
        logic signed [UW-1:0] sum;
        sum = UW'(signed'(cur)) + step;
`ifdef PERCEPTRON_SAT_EN
        if (sum > W_MAX) sum = W_MAX;
        if (sum < W_MIN) sum = W_MIN;
`endif
        return sum[WW-1:0];
    endfunction

    function automatic logic signed [UW-1:0] xstep(input logic [XW-1:0] x, input logic neg);
        logic signed [UW-1:0] s;
        s = UW'(signed'(x)) <<< LR_SHIFT;
        return neg ? -s : s;
    endfunction

    always_comb begin
        net_c = NW'(signed'(b));
        for (int i = 0; i < NUM_IN; i++)
            net_c = net_c + (NW'(signed'(w[i*WW +: WW])) * NW'(signed'(x_r[i*XW +: XW])));
    end

    assign ep_next     = (epoch_count == 16'hFFFF) ? epoch_count : epoch_count + 16'd1;
    assign ep_limit    = (ep_next >= EPOCH_LIMIT);
    assign last_sample = ((cnt + 32'd1) >= n_r);
    // t_r[0]=1 marks a valid target, t_r[1] is its sign; y is the sign bit of net
    assign mis         = t_r[0] && (net_r[NW-1] != t_r[1]);
    assign smp.request = (state == REQ);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (n_samples == 32'd0) ? EPOCH_END : REQ;
            REQ:        if (smp.data_ready) state_nxt = COMPUTE;
            COMPUTE:    state_nxt = UPDATE;
            UPDATE:     state_nxt = last_sample ? EPOCH_END : REQ;
            EPOCH_END:  state_nxt = (!err || ep_limit) ? DONE : REQ;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r         <= '0;
            t_r         <= '0;
            net_r       <= '0;
            cnt         <= '0;
            n_r         <= '0;
            err         <= 1'b0;
            converged   <= 1'b0;
            w           <= '0;
            b           <= '0;
            epoch_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    w           <= '0;
                    b           <= '0;
                    epoch_count <= '0;
                    cnt         <= '0;
                    err         <= 1'b0;
                    converged   <= 1'b0;
                    n_r         <= n_samples;
                end
                REQ: if (smp.data_ready) begin
                    x_r <= smp.x_in;
                    t_r <= smp.t_in;
                end
                COMPUTE: net_r <= net_c;
                UPDATE: begin
                    cnt <= cnt + 32'd1;
                    if (mis) begin
                        err <= 1'b1;
                        for (int i = 0; i < NUM_IN; i++)
                            w[i*WW +: WW] <= upd(w[i*WW +: WW], xstep(x_r[i*XW +: XW], t_r[1]));
                        b <= upd(b, t_r[1] ? -B_STEP : B_STEP);
                    end
                end
                EPOCH_END: begin
                    epoch_count <= ep_next;
                    if (!err)          converged <= 1'b1;
                    else if (ep_limit) converged <= 1'b0;
                    else begin
                        err <= 1'b0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench: scenario table, handshake/reset sequences, random sets vs model
module tb_perceptron_trainer;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0, dr = 1'b0;
    logic [31:0] nsamp = '0;
    logic [15:0] x_drv = '0;
    logic [1:0]  t_drv = '0;

    logic        done_a, conv_a, done_b, conv_b;
    logic [27:0] w_a;
    logic [13:0] b_a;
    logic [15:0] w_b, ep_a, ep_b;
    logic [7:0]  b_b;

    perceptron_trainer_if #(.NUM_IN(2), .XW(7)) ifa ();
    perceptron_trainer_if #(.NUM_IN(2), .XW(8)) ifb ();
    assign ifa.x_in = {x_drv[14:8], x_drv[6:0]};
    assign ifa.t_in = t_drv;
    assign ifa.data_ready = dr;
    assign ifb.x_in = x_drv;
    assign ifb.t_in = t_drv;
    assign ifb.data_ready = dr;

    perceptron_trainer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .n_samples(nsamp), .smp(ifa),
        .done(done_a), .converged(conv_a), .w(w_a), .b(b_a), .epoch_count(ep_a));

    perceptron_trainer #(.NUM_IN(2), .XW(8), .WW(8), .LR_SHIFT(1), .MAX_EPOCH(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .n_samples(nsamp), .smp(ifb),
        .done(done_b), .converged(conv_b), .w(w_b), .b(b_b), .epoch_count(ep_b));

    int total = 0, bad = 0;
    int sx0 [8], sx1 [8], st [8];

    typedef struct {
        int     n;
        int     x0 [4];
        int     x1 [4];
        int     t  [4];
        longint ew0, ew1, eb;
        int     eep;
        int     econv;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic dn(input bit sel);    return sel ? done_b : done_a;       endfunction
    function automatic logic rq(input bit sel);    return sel ? ifb.request : ifa.request; endfunction
    function automatic int   get_ep(input bit sel); return sel ? int'(ep_b) : int'(ep_a); endfunction
    function automatic longint gw(input bit sel, input int i);
        if (sel) return (i == 0) ? longint'($signed(w_b[7:0])) : longint'($signed(w_b[15:8]));
        return (i == 0) ? longint'($signed(w_a[13:0])) : longint'($signed(w_a[27:14]));
    endfunction
    function automatic longint gb(input bit sel);
        return sel ? longint'($signed(b_b)) : longint'($signed(b_a));
    endfunction

    function automatic longint fix(input longint v, input int ww);
        longint hi, m, r;
        hi = (64'sd1 <<< (ww - 1)) - 1;
        m  = 64'sd1 <<< ww;
        r  = v;
`ifdef PERCEPTRON_SAT_EN
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
`else
        r = r % m;
        if (r < 0) r = r + m;
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    // Plain-arithmetic perceptron: epochs over the sample arrays until error-free or the epoch limit
    task automatic model(input int n, input int ww, input int lr, input int maxep,
                         output longint mw0, output longint mw1, output longint mb,
                         output int mep, output int mconv);
        longint net, tv, y;
        int err;
        mw0 = 0; mw1 = 0; mb = 0; mep = 0; mconv = 0;
        for (int e = 0; e < 70000; e++) begin
            err = 0;
            for (int s = 0; s < n; s++) begin
                tv  = (st[s] == 1) ? 1 : (st[s] == 3) ? -1 : 0;
                net = mw0 * sx0[s] + mw1 * sx1[s] + mb;
                y   = (net >= 0) ? 1 : -1;
                if (tv != 0 && y != tv) begin
                    mw0 = fix(mw0 + tv * sx0[s] * (64'sd1 <<< lr), ww);
                    mw1 = fix(mw1 + tv * sx1[s] * (64'sd1 <<< lr), ww);
                    mb  = fix(mb + tv * (64'sd1 <<< lr), ww);
                    err = 1;
                end
            end
            if (mep < 65535) mep++;
            if (err == 0) begin mconv = 1; break; end
            if (mep >= maxep) begin mconv = 0; break; end
        end
    endtask

    // Feeds sample k0,k0+1,... (mod n) on each request with a random 0..maxd cycle stall.
    // stop_ep>0: return one cycle after accepting a sample while epoch_count>=stop_ep (DUT in COMPUTE).
    task automatic run(input bit sel, input int n, input int maxd, input bit do_start,
                       input int stop_ep, input int k0, output int cyc);
        int acc, k, d, lat_bad;
        bit stopping;
        cyc = 0; acc = -1; k = k0; d = -1; lat_bad = 0; stopping = 1'b0;
        if (do_start) begin
            nsamp = n;
            if (sel) start_b = 1'b1; else start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
        end
        while (!dn(sel) && cyc < 30000) begin
            dr = 1'b0; x_drv = 16'($urandom); t_drv = 2'($urandom);
            if (rq(sel)) begin
                if (d < 0) begin
                    if (acc >= 0 && (k % n) != 0 && cyc - acc != 3) lat_bad++;
                    d = $urandom_range(0, maxd);
                end
                if (d == 0) begin
                    x_drv = {8'(sx1[k % n]), 8'(sx0[k % n])};
                    t_drv = 2'(st[k % n]);
                    dr = 1'b1; acc = cyc; k++; d = -1;
                    stopping = (stop_ep > 0) && (get_ep(sel) >= stop_ep);
                end else d--;
            end
            @(negedge clk);
            cyc++;
            if (stopping) begin dr = 1'b0; return; end
        end
        dr = 1'b0;
        chk("run_timeout", longint'(cyc < 30000), 1);
        chk("sample_latency_violations", lat_bad, 0);
    endtask

    task automatic load(input int i);
        for (int s = 0; s < 4; s++) begin
            sx0[s] = tbl[i].x0[s]; sx1[s] = tbl[i].x1[s]; st[s] = tbl[i].t[s];
        end
    endtask

    task automatic check_and_result(input string tag);
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_conv"}, conv_a, 1);
        chk({tag, "_ep"}, ep_a, 3);
        chk({tag, "_w0"}, gw(0, 0), 1);
        chk({tag, "_w1"}, gw(0, 1), 1);
        chk({tag, "_b"}, gb(0), -1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi, lat, n, sel, mep, mconv;
        longint mw0, mw1, mb, exp_w0;

        tbl[0] = '{4, '{1, 1, -1, -1}, '{1, -1, 1, -1}, '{1, 3, 3, 3}, 1, 1, -1, 3, 1};
        tbl[1] = '{0, '{0, 0, 0, 0},   '{0, 0, 0, 0},   '{0, 0, 0, 0}, 0, 0, 0, 1, 1};
        tbl[2] = '{2, '{5, -7, 0, 0},  '{3, 9, 0, 0},   '{0, 2, 0, 0}, 0, 0, 0, 1, 1};
        tbl[3] = '{1, '{1, 0, 0, 0},   '{0, 0, 0, 0},   '{1, 0, 0, 0}, 0, 0, 0, 1, 1};
        tbl[4] = '{1, '{2, 0, 0, 0},   '{3, 0, 0, 0},   '{3, 0, 0, 0}, -2, -3, -1, 2, 1};

        repeat (3) @(negedge clk);
        chk("rst_request", ifa.request, 0);
        chk("rst_done", done_a, 0);
        chk("rst_conv", conv_a, 0);
        chk("rst_w", w_a, 0);
        chk("rst_b", b_a, 0);
        chk("rst_ep", ep_a, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_request", ifa.request, 0);
        chk("idle_no_done", done_a, 0);

        for (int i = 0; i < 5; i++) begin
            load(i);
            run(0, tbl[i].n, 1, 1, 0, 0, cyc);
            chk($sformatf("tbl%0d_done", i), done_a, 1);
            chk($sformatf("tbl%0d_conv", i), conv_a, tbl[i].econv);
            chk($sformatf("tbl%0d_ep", i), ep_a, tbl[i].eep);
            chk($sformatf("tbl%0d_w0", i), gw(0, 0), tbl[i].ew0);
            chk($sformatf("tbl%0d_w1", i), gw(0, 1), tbl[i].ew1);
            chk($sformatf("tbl%0d_b", i), gb(0), tbl[i].eb);
            if (tbl[i].n == 0) chk("zero_samples_cycles", cyc, 1);
            dr = 1'b1;
            repeat (3) @(negedge clk);
            dr = 1'b0;
            chk($sformatf("tbl%0d_hold_done", i), done_a, 1);
            chk($sformatf("tbl%0d_hold_b", i), gb(0), tbl[i].eb);
        end

        // Stall in REQ for 5 cycles, with an ignored start pulse, then measure request spacing
        load(0);
        nsamp = 4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (ifa.request) hi++;
            start_a = (i == 2);
            nsamp = (i == 2) ? 0 : 4;
            @(negedge clk);
        end
        start_a = 1'b0; nsamp = 4;
        chk("stall_request_high", hi, 5);
        chk("stall_request_still", ifa.request, 1);
        chk("stall_ep", ep_a, 0);
        x_drv = {8'(sx1[0]), 8'(sx0[0])}; t_drv = 2'(st[0]); dr = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        chk("accept_request_fall", ifa.request, 0);
        lat = 1;
        while (!ifa.request && lat < 10) begin @(negedge clk); lat++; end
        chk("accept_to_request", lat, 3);
        run(0, 4, 0, 0, 0, 1, cyc);
        check_and_result("stalled_and");

        // Reset while in COMPUTE of epoch 2
        run(0, 4, 1, 1, 1, 0, cyc);
        rst = 1'b0;
        #1;
        chk("midrst_request", ifa.request, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_conv", conv_a, 0);
        chk("midrst_w", w_a, 0);
        chk("midrst_b", b_a, 0);
        chk("midrst_ep", ep_a, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_idle", ifa.request, 0);
        run(0, 4, 2, 1, 0, 0, cyc);
        check_and_result("after_rst_and");

        // Narrow weights: first update of (100,0,-1) either clamps or wraps
`ifdef PERCEPTRON_SAT_EN
        exp_w0 = -128;
`else
        exp_w0 = 56;
`endif
        sx0[0] = 100; sx1[0] = 0; st[0] = 3;
        run(1, 1, 0, 1, 1, 0, cyc);
        chk("narrow_w0_first", gw(1, 0), exp_w0);
        chk("narrow_b_first", gb(1), -2);
        run(1, 1, 0, 0, 0, 0, cyc);
        model(1, 8, 1, 3, mw0, mw1, mb, mep, mconv);
        chk("narrow_final_w0", gw(1, 0), mw0);
        chk("narrow_final_ep", ep_b, mep);
        chk("narrow_final_conv", conv_b, mconv);

        // Non-separable pair hits the epoch limit
        sx0[0] = 1; sx1[0] = 0; st[0] = 1;
        sx0[1] = 1; sx1[1] = 0; st[1] = 3;
        run(1, 2, 1, 1, 0, 0, cyc);
        chk("nonsep_done", done_b, 1);
        chk("nonsep_conv", conv_b, 0);
        chk("nonsep_ep", ep_b, 3);

        for (int r = 0; r < 12; r++) begin
            sel = r % 2;
            n = $urandom_range(1, 4);
            for (int s = 0; s < n; s++) begin
                sx0[s] = sel ? $urandom_range(0, 255) - 128 : $urandom_range(0, 127) - 64;
                sx1[s] = sel ? $urandom_range(0, 255) - 128 : $urandom_range(0, 127) - 64;
                case ($urandom_range(0, 5))
                    0, 1:    st[s] = 1;
                    2, 3:    st[s] = 3;
                    4:       st[s] = 0;
                    default: st[s] = 2;
                endcase
            end
            if (sel == 1) model(n, 8, 1, 3, mw0, mw1, mb, mep, mconv);
            else          model(n, 14, 0, 255, mw0, mw1, mb, mep, mconv);
            run(sel[0], n, 2, 1, 0, 0, cyc);
            chk($sformatf("rnd%0d_w0", r), gw(sel[0], 0), mw0);
            chk($sformatf("rnd%0d_w1", r), gw(sel[0], 1), mw1);
            chk($sformatf("rnd%0d_b", r), gb(sel[0]), mb);
            chk($sformatf("rnd%0d_ep", r), get_ep(sel[0]), mep);
            chk($sformatf("rnd%0d_conv", r), sel ? conv_b : conv_a, mconv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 Parameters SHALL be: NUM_IN, default 2, input channel count (1..8); XW, default 7, signed sample width; WW, default 14, signed weight/bias width; LR_SHIFT, default 0, learning rate 2^LR_SHIFT; MAX_EPOCH, default 255, epoch limit.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse that begins training; honoured only in IDLE or DONE.
REQ-005 n_samples  in  32  samples per epoch, sampled on start.
REQ-006 x_in  in  NUM_IN*XW  packed signed samples, channel i at bits [i*XW +: XW].
REQ-007 t_in  in  2  target: 01 = +1, 11 = -1, 00/10 = invalid.
REQ-008 data_ready  in  1  source holds valid x_in/t_in.
REQ-009 request  out  1  trainer wants the next sample.
REQ-010 done  out  1  training finished; held until next start.
REQ-011 converged  out  1  the final epoch had zero errors; valid while done=1.
REQ-012 w  out  NUM_IN*WW  packed signed weights.
REQ-013 b  out  WW  signed bias.
REQ-014 epoch_count  out  16  epochs completed.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, COMPUTE, UPDATE, EPOCH_END and DONE.
REQ-016 start SHALL clear w, b, epoch_count, the sample counter and the error flag, then go to EPOCH_END if n_samples==0, otherwise to REQ.
REQ-017 request SHALL be 1 only in REQ; a sample SHALL be accepted on the cycle request && data_ready, with x_in/t_in registered and the FSM moving to COMPUTE.
REQ-018 COMPUTE SHALL register net = sum(w_i*x_i) + b at full precision, with no overflow, in one cycle.
REQ-019 y SHALL be +1 if net >= 0, else -1.
REQ-020 UPDATE SHALL apply w_i += t*(x_i<<LR_SHIFT) and b += t*(1<<LR_SHIFT), and set the error flag, iff t is valid and y != t; invalid t SHALL cause no update and no error.
REQ-021 Per-sample latency SHALL be exactly 3 cycles from acceptance to the next request.
REQ-022 After UPDATE, the FSM SHALL go to EPOCH_END when the sample counter reaches n_samples, otherwise to REQ.
REQ-023 EPOCH_END SHALL increment epoch_count, which saturates at 0xFFFF.
REQ-024 From EPOCH_END, the FSM SHALL go to DONE with converged=1 if the error flag is 0, or to DONE with converged=0 if epoch_count==MAX_EPOCH; otherwise it SHALL clear the flag and counter and return to REQ.
REQ-025 start asserted outside IDLE/DONE SHALL be ignored; data_ready outside REQ SHALL be ignored.
REQ-026 w, b and epoch_count SHALL hold their values in DONE.

Reset
REQ-027 rst low SHALL immediately force IDLE and drive request=0, done=0, converged=0, w=0, b=0, epoch_count=0, counters=0, with an in-flight sample discarded.
REQ-028 After rst is released, the trainer SHALL take no action until start.

Configuration
REQ-029 With PERCEPTRON_SAT_EN defined, each weight/bias update SHALL saturate to [-2^(WW-1), 2^(WW-1)-1].
REQ-030 Without PERCEPTRON_SAT_EN, updates SHALL wrap modulo 2^WW (two's complement).

Verification
REQ-031 AND set, defaults: samples (1,1,+1),(1,-1,-1),(-1,1,-1),(-1,-1,-1), n_samples=4 -> done, converged=1, epoch_count=3, w=(1,1), b=-1.
REQ-032 Handshake: data_ready withheld 5 cycles in REQ -> request stays 1 and no state change; on acceptance -> request falls, next request exactly 3 cycles later.
REQ-033 Saturation: WW=8, LR_SHIFT=1, sample (100,0,-1) -> with macro, w0=-128 and b=-2 after the first update; without macro, w0=56 and b=-2.
REQ-034 Non-separable set (1,0,+1),(1,0,-1), MAX_EPOCH=3 -> done, converged=0, epoch_count=3.
REQ-035 rst pulsed low mid-COMPUTE during epoch 2 -> all outputs 0 immediately, IDLE; a fresh start reproduces the REQ-031 result.
REQ-036 n_samples=0 plus start -> done and converged=1 after 2 cycles, epoch_count=1, w=0, b=0; t_in=00 samples -> no update.
